dot_matrix_scan: RTL and testbench

DOT_MATRIX_SCAN -- requirements
Module: dot_matrix_scan

---
 rtl/dot_matrix_pkg.sv | 7 +
 rtl/dot_matrix_scan_divider.sv | 23 ++
 rtl/dot_matrix_scan.sv | 105 ++++++++++
 tb/tb_dot_matrix_scan.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/dot_matrix_pkg.sv
// Shared state encoding and matrix geometry for the 16x16 dot-matrix row scanner.
package dot_matrix_pkg;
    localparam int MATRIX_ROWS = 16;
    localparam int MATRIX_COLS = 16;

    typedef enum logic [1:0] {IDLE, FETCH, SHOW, BLANK} scan_state_t;
endpackage

// File: rtl/dot_matrix_scan_divider.sv
// Terminal-count dwell counter: counts up from 0 while clr is low; done is high while count equals term.
module scan_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             done
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

    assign done = (count == term);
endmodule

// File: rtl/dot_matrix_scan.sv
// Row scanner for a 16x16 dot matrix: FETCH a ROM row, SHOW it for CLK_DIV cycles, optionally BLANK.
// Define SCAN_BLANK_EN to insert BLANK_CYC dark cycles between rows.
module dot_matrix_scan
    import dot_matrix_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic [3:0]             row_bin,
    input  logic [MATRIX_COLS-1:0] col_in,
    output logic [MATRIX_ROWS-1:0] row_out,
    output logic [MATRIX_COLS-1:0] col_out,
    output logic                   frame_tick
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BLK_W = $clog2(BLANK_CYC);
    localparam int CNT_W = (DIV_W > BLK_W) ? DIV_W : BLK_W;

    localparam logic [CNT_W-1:0]       SHOW_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]       TICK_AT   = CNT_W'(CLK_DIV - 2);
    localparam logic [MATRIX_ROWS-1:0] ROW0      = MATRIX_ROWS'(1);
    localparam logic [3:0]             LAST_ROW  = 4'(MATRIX_ROWS - 1);

    scan_state_t      state;
    logic [3:0]       row;
    logic [CNT_W-1:0] term;
    logic [CNT_W-1:0] cnt;
    logic             done;
    logic             clr;

`ifdef SCAN_BLANK_EN
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    assign term = (state == BLANK) ? BLANK_LAST : SHOW_LAST;
`else
    assign term = SHOW_LAST;
`endif

    // Clearing on every exit means the count always starts at 0 in the state being entered.
    assign clr = !en || (state == IDLE) || (state == FETCH) || done;

    scan_divider #(.WIDTH(CNT_W)) u_div (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .term  (term),
        .count (cnt),
        .done  (done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            row_bin    <= '0;
            row_out    <= '0;
            col_out    <= '0;
            frame_tick <= 1'b0;
        end else if (!en) begin
            state      <= IDLE;
            row        <= '0;
            row_bin    <= '0;
            row_out    <= '0;
            col_out    <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    state   <= SHOW;
                    row_out <= ROW0 << row;
                    col_out <= col_in;
                end
                SHOW: begin
                    if (done) begin
                        row     <= row + 4'd1;
                        row_out <= '0;
                        col_out <= '0;
`ifdef SCAN_BLANK_EN
                        state   <= BLANK;
`else
                        state   <= FETCH;
                        row_bin <= row + 4'd1;
`endif
                    end else begin
                        // Registered, so raised one cycle early to land on the last SHOW cycle.
                        frame_tick <= (row == LAST_ROW) && (cnt == TICK_AT);
                    end
                end
`ifdef SCAN_BLANK_EN
                BLANK: begin
                    if (done) begin
                        state   <= FETCH;
                        row_bin <= row;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dot_matrix_scan.sv
// Scoreboard bench for dot_matrix_scan: per-cycle expected outputs from a timeline model of the scan.
module tb_dot_matrix_scan;
    localparam int CLK_DIV   = 4;
    localparam int BLANK_CYC = 2;
`ifdef SCAN_BLANK_EN
    localparam int GAP = BLANK_CYC;
`else
    localparam int GAP = 0;
`endif
    localparam int P = 1 + CLK_DIV + GAP;

    typedef struct packed {
        logic [3:0]  rb;
        logic [15:0] ro;
        logic [15:0] co;
        logic        ft;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  row_bin;
    logic [15:0] col_in;
    logic [15:0] row_out;
    logic [15:0] col_out;
    logic        frame_tick;

    logic [15:0] rom [16];
    obs_t        exp_q[$];
    obs_t        mon_want;
    obs_t        mon_got;
    obs_t        e_show;
    int          total = 0;
    int          bad = 0;
    int          k = 0;

    dot_matrix_scan #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .row_bin    (row_bin),
        .col_in     (col_in),
        .row_out    (row_out),
        .col_out    (col_out),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // k counts cycles since the scan (re)started: k=1 is FETCH of row 0, each row spans P cycles.
    function automatic obs_t model(input int kk);
        obs_t o;
        int   ph;
        int   r;
        o = '0;
        if (kk > 0) begin
            ph   = (kk - 1) % P;
            r    = ((kk - 1) / P) % 16;
            o.rb = 4'(r);
            if (ph >= 1 && ph <= CLK_DIV) begin
                o.ro = 16'(1) << r;
                o.co = rom[r];
            end
            o.ft = (ph == CLK_DIV) && (r == 15);
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic step(input logic en_v, input logic rst_v);
        @(negedge clk);
        en  = en_v;
        rst = rst_v;
        if (rst_v || !en_v) k = 0;
        else k++;
        exp_q.push_back(model(k));
    endtask

    // Pattern ROM; during SHOW the column input is toggled every cycle to prove it is not re-sampled.
    always @(negedge clk) begin
        if (row_out != '0) col_in = ~col_in;
        else col_in = rom[row_bin];
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_want = exp_q.pop_front();
                mon_got  = {row_bin, row_out, col_out, frame_tick};
                total++;
                if (mon_got !== mon_want) begin
                    bad++;
                    $display("FAIL outputs t=%0t got rb=%h ro=%h co=%h ft=%b want rb=%h ro=%h co=%h ft=%b",
                             $time, mon_got.rb, mon_got.ro, mon_got.co, mon_got.ft,
                             mon_want.rb, mon_want.ro, mon_want.co, mon_want.ft);
                end
            end
        end
    end

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        col_in = '0;
        for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
        rom[1] = 16'h0FF0;
        rom[2] = 16'h0800;
        #1;
        check("reset_outputs", 64'({row_bin, row_out, col_out, frame_tick}), 64'd0);

        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        repeat (2 * 16 * P) step(1'b1, 1'b0);

        for (int n = 0; n < 16 * P && !(k > 0 && ((k - 1) % P) == 2 && ((k - 1) / P) % 16 == 5); n++)
            step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        repeat (3 * P) step(1'b1, 1'b0);

        repeat (600) step($urandom_range(0, 49) != 0, 1'b0);

        step(1'b1, 1'b0);
        for (int n = 0; n < 4 * P && !(k > 0 && ((k - 1) % P) == 2); n++)
            step(1'b1, 1'b0);
        @(negedge clk);
        e_show = model(k);
        check("show_before_rst", 64'(row_out), 64'(e_show.ro));
        rst = 1'b1;
        #1;
        check("async_rst_row", 64'(row_out), 64'd0);
        check("async_rst_col", 64'(col_out), 64'd0);
        k = 0;
        exp_q.push_back(model(0));
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        repeat (3 * P) step(1'b1, 1'b0);

        @(posedge clk);
        #3;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
